// File: rtl/pr_timer.sv
// Memory-mapped countdown timer (one-shot / auto-reload) with maskable IRQ.
// Optional PRESCALE register and tick divider enabled by `define TIMER_PRESCALE_EN.
module pr_timer #(
    parameter logic [31:0] PRESET_RST      = 32'h0000_0000,
    parameter int unsigned IRQ_MODE1_PULSE = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, CNT, INT} state_t;

    state_t      state, state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_next;
    logic        flag, flag_next;
    logic        en_clr;
    logic        ctrl_wr;
    logic        tick;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] div, div_next;
`endif

    assign ctrl_wr = We && (Addr == 2'd0);

`ifdef TIMER_PRESCALE_EN
    // >= rather than == so a PRESCALE lowered mid-count never strands the divider
    assign tick = (div >= prescale);
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_next = state;
        count_next = count;
        flag_next  = flag;
        en_clr     = 1'b0;
`ifdef TIMER_PRESCALE_EN
        div_next   = div;
`endif
        if (ctrl_wr)
            flag_next = 1'b0;

        case (state)
            IDLE: begin
                if (ctrl[0]) begin
                    count_next = preset;
                    state_next = CNT;
`ifdef TIMER_PRESCALE_EN
                    div_next   = '0;
`endif
                end
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_next = IDLE;
                end else if (!tick) begin
`ifdef TIMER_PRESCALE_EN
                    div_next = div + 16'd1;
`endif
                end else begin
`ifdef TIMER_PRESCALE_EN
                    div_next = '0;
`endif
                    if (count > 32'd1) begin
                        count_next = count - 32'd1;
                    end else begin
                        // set takes priority over a same-edge CTRL write clear
                        count_next = '0;
                        flag_next  = 1'b1;
                        state_next = INT;
                    end
                end
            end
            INT: begin
                state_next = IDLE;
                if (ctrl[2:1] == 2'b01) begin
                    if (IRQ_MODE1_PULSE != 0)
                        flag_next = 1'b0;
                end else begin
                    en_clr = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef TIMER_PRESCALE_EN
        if (ctrl_wr)
            div_next = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= IDLE;
            ctrl   <= '0;
            preset <= PRESET_RST;
            count  <= '0;
            flag   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale <= '0;
            div      <= '0;
`endif
        end else begin
            state <= state_next;
            count <= count_next;
            flag  <= flag_next;
            if (ctrl_wr)
                ctrl <= Din[3:0];
            else if (en_clr)
                ctrl[0] <= 1'b0;
            if (We && (Addr == 2'd1))
                preset <= Din;
`ifdef TIMER_PRESCALE_EN
            if (We && (Addr == 2'd3))
                prescale <= Din[15:0];
            div <= div_next;
`endif
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0: Dout = {28'd0, ctrl};
            2'd1: Dout = preset;
            2'd2: Dout = count;
`ifdef TIMER_PRESCALE_EN
            2'd3: Dout = {16'd0, prescale};
`else
            2'd3: Dout = '0;
`endif
            default: Dout = '0;
        endcase
    end

    assign IRQ = ctrl[3] & flag;

endmodule

// File: tb/tb_pr_timer.sv
// Directed vector bench for pr_timer: table of bus cycles with expected read-back
// and IRQ, plus a hand sequence measuring the auto-reload IRQ period.
module tb_pr_timer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    pr_timer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .Addr  (Addr),
        .We    (We),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [1:0] addr, input logic [31:0] din,
                       input logic [1:0] raddr, input logic [31:0] exp_dout, input logic exp_irq);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din;
        v.raddr = raddr; v.exp_dout = exp_dout; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endtask

    // one bus cycle: drive at negedge, clock it, then read back raddr
    task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] din);
        @(negedge clk);
        We = we; Addr = addr; Din = din;
        @(posedge clk);
        #1;
        We = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        int first_rise, second_rise, width, prev;

        // reset
        add(0, 0, 0, 0, 32'h0, 0);
        add(0, 0, 0, 1, 32'h0, 0);
        add(0, 0, 0, 2, 32'h0, 0);
        // one-shot, PRESET=3
        add(1, 1, 3, 1, 3, 0);
        add(1, 0, 32'h9, 2, 0, 0);
        add(0, 0, 0, 2, 3, 0);
        add(0, 0, 0, 2, 2, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 32'h8, 1);
        add(0, 0, 0, 2, 0, 1);
        add(1, 0, 32'h8, 0, 32'h8, 0);
        // auto-reload, PRESET=2
        add(1, 1, 2, 1, 2, 0);
        add(1, 0, 32'hB, 2, 0, 0);
        add(0, 0, 0, 2, 2, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 2, 2, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 2, 0, 0);
        add(1, 0, 32'h0, 2, 2, 0);
        add(0, 0, 0, 2, 2, 0);
        // stop mid-count, PRESET=10
        add(1, 1, 10, 1, 10, 0);
        add(1, 0, 32'h1, 2, 2, 0);
        add(0, 0, 0, 2, 10, 0);
        add(0, 0, 0, 2, 9, 0);
        add(0, 0, 0, 2, 8, 0);
        add(0, 0, 0, 2, 7, 0);
        add(1, 0, 32'h0, 2, 6, 0);
        add(0, 0, 0, 2, 6, 0);
        add(0, 0, 0, 0, 32'h0, 0);
        add(1, 0, 32'h1, 2, 6, 0);
        add(0, 0, 0, 2, 10, 0);
        add(1, 0, 32'h0, 2, 9, 0);
        add(0, 0, 0, 2, 9, 0);
        add(1, 2, 32'h1234, 2, 9, 0);
        // PRESET=0, masked IRQ, bus write wins in INT
        add(1, 1, 0, 1, 0, 0);
        add(1, 0, 32'h1, 2, 9, 0);
        add(0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 2, 0, 0);
        add(1, 0, 32'hB, 0, 32'hB, 0);
        add(0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 2, 0, 0);
        add(1, 0, 32'h0, 2, 0, 0);
        add(0, 0, 0, 0, 32'h0, 0);
        // CTRL write on the edge that sets the flag
        add(1, 1, 1, 1, 1, 0);
        add(1, 0, 32'h9, 2, 0, 0);
        add(0, 0, 0, 2, 1, 0);
        add(1, 0, 32'h9, 0, 32'h9, 1);
        add(0, 0, 0, 0, 32'h8, 1);
        add(1, 0, 32'h0, 0, 32'h0, 0);
`ifdef TIMER_PRESCALE_EN
        add(1, 3, 1, 3, 1, 0);
        add(1, 1, 3, 1, 3, 0);
        add(1, 0, 32'h9, 2, 0, 0);
        add(0, 0, 0, 2, 3, 0);
        add(0, 0, 0, 2, 3, 0);
        add(0, 0, 0, 2, 2, 0);
        add(0, 0, 0, 2, 2, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 32'h8, 1);
        add(1, 0, 32'h0, 0, 32'h0, 0);
        add(1, 3, 0, 3, 0, 0);
`else
        add(1, 3, 32'hFFFF, 3, 0, 0);
`endif

        We = 1'b0; Addr = 2'd0; Din = '0; clr_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].din);
            Addr = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_dout", i), Dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vecs[i].exp_irq});
        end

        // auto-reload period: PRESET=5 gives first IRQ 6 edges after enable, period 7
        step(1, 1, 5);
        step(1, 0, 32'hB);
        Addr = 2'd2;
        first_rise = 0; second_rise = 0; width = 0; prev = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (IRQ && !prev) begin
                if (first_rise == 0) first_rise = k;
                else if (second_rise == 0) second_rise = k;
            end
            if (IRQ && first_rise != 0 && second_rise == 0) width++;
            prev = IRQ ? 1 : 0;
        end
        check("mode1_first_irq", first_rise, 6);
        check("mode1_period", second_rise - first_rise, 7);
        check("mode1_pulse_width", width, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
